// File: rtl/torus_pe_array.sv
// torus_pe_array: ROWS x COLS torus of PE/PEIO nodes with a Start/Done run controller.
// Nodes k < NUM_IO are PEIO nodes bound to load/store channel k; links wrap in both dimensions.
module torus_pe #(
    parameter int DWIDTH = 32,
    parameter int ID     = 0
) (
    input  logic              Clk,
    input  logic              Resetn,
    input  logic              PE_Array_Busy,
    input  logic [DWIDTH-1:0] In0,
    input  logic [DWIDTH-1:0] In1,
    input  logic [DWIDTH-1:0] In2,
    input  logic [DWIDTH-1:0] In3,
    output logic [DWIDTH-1:0] Out0,
    output logic [DWIDTH-1:0] Out1,
    output logic [DWIDTH-1:0] Out2,
    output logic [DWIDTH-1:0] Out3
);
    logic [DWIDTH-1:0] acc_q;
    always_ff @(posedge Clk or negedge Resetn)
        if (!Resetn) acc_q <= '0;
        else if (PE_Array_Busy) acc_q <= acc_q + (In0 ^ In1) + (In2 ^ In3);
    // each link carries a node/direction tag so neighbours stay distinguishable
    assign Out0 = acc_q ^ DWIDTH'(4*ID+1);
    assign Out1 = acc_q ^ DWIDTH'(4*ID+2);
    assign Out2 = acc_q ^ DWIDTH'(4*ID+3);
    assign Out3 = acc_q ^ DWIDTH'(4*ID+4);
endmodule

module torus_peio #(
    parameter int DWIDTH     = 32,
    parameter int SYS_DWIDTH = 32,
    parameter int ID         = 0
) (
    input  logic                  Clk,
    input  logic                  Resetn,
    input  logic                  PE_Array_Busy,
    input  logic [DWIDTH-1:0]     In0,
    input  logic [DWIDTH-1:0]     In1,
    input  logic [DWIDTH-1:0]     In2,
    input  logic [DWIDTH-1:0]     In3,
    input  logic [SYS_DWIDTH-1:0] PE_Load,
    output logic [SYS_DWIDTH-1:0] PE_Store,
    output logic [DWIDTH-1:0]     Out0,
    output logic [DWIDTH-1:0]     Out1,
    output logic [DWIDTH-1:0]     Out2,
    output logic [DWIDTH-1:0]     Out3
);
    logic [DWIDTH-1:0]     acc_q;
    logic [SYS_DWIDTH-1:0] store_q;
    always_ff @(posedge Clk or negedge Resetn)
        if (!Resetn) begin
            acc_q   <= '0;
            store_q <= '0;
        end else if (PE_Array_Busy) begin
            acc_q   <= acc_q + (In0 ^ In1) + (In2 ^ In3) + DWIDTH'(PE_Load);
            store_q <= SYS_DWIDTH'(acc_q);
        end
    assign PE_Store = store_q;
    assign Out0 = acc_q ^ DWIDTH'(4*ID+1);
    assign Out1 = acc_q ^ DWIDTH'(4*ID+2);
    assign Out2 = acc_q ^ DWIDTH'(4*ID+3);
    assign Out3 = acc_q ^ DWIDTH'(4*ID+4);
endmodule

module torus_pe_array #(
    parameter int ROWS       = 4,
    parameter int COLS       = 3,
    parameter int NUM_IO     = 2,
    parameter int DWIDTH     = 32,
    parameter int SYS_DWIDTH = 32,
    parameter int CNT_W      = 16,
    parameter int DRAIN_CYC  = 2
) (
    input  logic                         Clk,
    input  logic                         Resetn,
    input  logic                         Start,
    input  logic                         Abort,
    input  logic [CNT_W-1:0]             Run_Len,
    input  logic [NUM_IO*SYS_DWIDTH-1:0] Data_Load,
    output logic [NUM_IO*SYS_DWIDTH-1:0] Data_Store,
    output logic                         Busy,
    output logic                         Done,
    output logic [CNT_W-1:0]             Cycle_Cnt
);
    localparam int DRW = DRAIN_CYC > 1 ? $clog2(DRAIN_CYC) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t           state_q;
    logic [CNT_W-1:0] len_q, cnt_q;
    logic [DRW-1:0]   drain_q;
    logic             pe_array_busy;
    logic [DWIDTH-1:0] in_w  [ROWS][COLS][4];
    logic [DWIDTH-1:0] out_w [ROWS][COLS][4];
    always_ff @(posedge Clk or negedge Resetn)
        if (!Resetn) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (Start) begin
                    if (Run_Len != '0) begin
                        len_q   <= Run_Len;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end else state_q <= DONE;
                end
                RUN: begin
                    drain_q <= '0;
                    if (Abort) state_q <= IDLE;
                    else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == len_q - 1'b1) state_q <= DRAIN_CYC == 0 ? DONE : DRAIN;
                    end
                end
                DRAIN:
                    if (Abort) state_q <= IDLE;
                    else if (drain_q == DRW'(DRAIN_CYC-1)) state_q <= DONE;
                    else drain_q <= drain_q + 1'b1;
                default: state_q <= IDLE;
            endcase
        end
    assign Busy          = state_q != IDLE;
    assign Done          = state_q == DONE;
    assign pe_array_busy = state_q == RUN;
    assign Cycle_Cnt     = cnt_q;
    for (genvar r = 0; r < ROWS; r++) begin : g_r
        for (genvar c = 0; c < COLS; c++) begin : g_c
            localparam int K = r*COLS + c;
            assign in_w[r][c][0] = out_w[r][(c+COLS-1)%COLS][2];
            assign in_w[r][c][1] = out_w[(r+ROWS-1)%ROWS][c][3];
            assign in_w[r][c][2] = out_w[r][(c+1)%COLS][0];
            assign in_w[r][c][3] = out_w[(r+1)%ROWS][c][1];
            if (K < NUM_IO) begin : g_io
                torus_peio #(.DWIDTH(DWIDTH), .SYS_DWIDTH(SYS_DWIDTH), .ID(K)) u_node (
                    .Clk(Clk), .Resetn(Resetn), .PE_Array_Busy(pe_array_busy),
                    .In0(in_w[r][c][0]), .In1(in_w[r][c][1]), .In2(in_w[r][c][2]), .In3(in_w[r][c][3]),
                    .PE_Load(Data_Load[K*SYS_DWIDTH +: SYS_DWIDTH]),
                    .PE_Store(Data_Store[K*SYS_DWIDTH +: SYS_DWIDTH]),
                    .Out0(out_w[r][c][0]), .Out1(out_w[r][c][1]), .Out2(out_w[r][c][2]), .Out3(out_w[r][c][3])
                );
            end else begin : g_pe
                torus_pe #(.DWIDTH(DWIDTH), .ID(K)) u_node (
                    .Clk(Clk), .Resetn(Resetn), .PE_Array_Busy(pe_array_busy),
                    .In0(in_w[r][c][0]), .In1(in_w[r][c][1]), .In2(in_w[r][c][2]), .In3(in_w[r][c][3]),
                    .Out0(out_w[r][c][0]), .Out1(out_w[r][c][1]), .Out2(out_w[r][c][2]), .Out3(out_w[r][c][3])
                );
            end
        end
    end
endmodule

// File: tb/tb_torus_pe_array.sv
// tb_torus_pe_array: directed bench for the torus controller and link topology.
// Expected Done timing and final counts are queued at launch and checked when Done appears.
module tb_torus_pe_array;
    localparam int ROWS = 3, COLS = 5, NUM_IO = 4, DW = 32, SW = 32, CW = 16, DC = 2;
    logic                   Clk = 1'b0, Resetn = 1'b0, Start = 1'b0, Abort = 1'b0;
    logic [CW-1:0]          Run_Len = '0;
    logic [NUM_IO*SW-1:0]   Data_Load = '0;
    logic [NUM_IO*SW-1:0]   Data_Store;
    logic                   Busy, Done;
    logic [CW-1:0]          Cycle_Cnt;
    int n_run = 0, n_fail = 0, cyc = 0;
    int p, b, seen;
    typedef struct {int cyc; logic [CW-1:0] cnt; bit chk_cnt;} exp_t;
    exp_t sb[$];

    torus_pe_array #(.ROWS(ROWS), .COLS(COLS), .NUM_IO(NUM_IO), .DWIDTH(DW), .SYS_DWIDTH(SW),
                     .CNT_W(CW), .DRAIN_CYC(DC)) dut (
        .Clk(Clk), .Resetn(Resetn), .Start(Start), .Abort(Abort), .Run_Len(Run_Len),
        .Data_Load(Data_Load), .Data_Store(Data_Store), .Busy(Busy), .Done(Done), .Cycle_Cnt(Cycle_Cnt)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // node tag as seen on an output link while the accumulators are still zero
    function automatic int tag_of(input int r, input int c, input int d);
        return 4*(r*COLS + c) + d + 1;
    endfunction

    task automatic launch(input logic [CW-1:0] len, input bit push);
        Start = 1'b1;
        Run_Len = len;
        if (push) sb.push_back('{cyc + 1 + (len == 0 ? 0 : int'(len) + DC), len, len != 0});
    endtask

    task automatic wait_done(input int budget, output int pab_n, output int busy_n);
        exp_t e;
        pab_n = 0;
        busy_n = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            Start = 1'b0;
            Run_Len = CW'($urandom);
            pab_n += int'(dut.pe_array_busy);
            busy_n += int'(Busy);
            if (Done) begin
                if (sb.size() != 0) e = sb.pop_front();
                else e = '{-1, '0, 1'b0};
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                if (e.chk_cnt) chk("cnt_at_done", 64'(Cycle_Cnt), 64'(e.cnt));
                return;
            end
        end
        n_run++;
        n_fail++;
        $error("FAIL done_timeout: observed no Done within %0d cycles, expected a Done pulse", budget);
    endtask

    initial begin
        repeat (2) @(negedge Clk);
        Resetn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            chk("idle_busy", 64'(Busy), 64'(0));
            chk("idle_done", 64'(Done), 64'(0));
            chk("idle_cnt", 64'(Cycle_Cnt), 64'(0));
            chk("idle_pab", 64'(dut.pe_array_busy), 64'(0));
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                chk($sformatf("link_%0d_%0d_in0", r, c), 64'(dut.in_w[r][c][0]), 64'(tag_of(r, (c+COLS-1)%COLS, 2)));
                chk($sformatf("link_%0d_%0d_in1", r, c), 64'(dut.in_w[r][c][1]), 64'(tag_of((r+ROWS-1)%ROWS, c, 3)));
                chk($sformatf("link_%0d_%0d_in2", r, c), 64'(dut.in_w[r][c][2]), 64'(tag_of(r, (c+1)%COLS, 0)));
                chk($sformatf("link_%0d_%0d_in3", r, c), 64'(dut.in_w[r][c][3]), 64'(tag_of((r+1)%ROWS, c, 1)));
            end
        chk("pe_node4_out0", 64'(dut.g_r[0].g_c[4].g_pe.u_node.Out0), 64'(tag_of(0, 4, 0)));
        Data_Load = {$urandom, $urandom, $urandom, $urandom};
        #1;
        chk("io0_load", 64'(dut.g_r[0].g_c[0].g_io.u_node.PE_Load), 64'(Data_Load[0*SW +: SW]));
        chk("io1_load", 64'(dut.g_r[0].g_c[1].g_io.u_node.PE_Load), 64'(Data_Load[1*SW +: SW]));
        chk("io2_load", 64'(dut.g_r[0].g_c[2].g_io.u_node.PE_Load), 64'(Data_Load[2*SW +: SW]));
        chk("io3_load", 64'(dut.g_r[0].g_c[3].g_io.u_node.PE_Load), 64'(Data_Load[3*SW +: SW]));
        @(negedge Clk);
        launch(5, 1'b1);
        wait_done(20, p, b);
        chk("run5_pab_cycles", 64'(p), 64'(5));
        chk("run5_busy_cycles", 64'(b), 64'(8));
        @(negedge Clk);
        chk("after_run_busy", 64'(Busy), 64'(0));
        chk("after_run_done", 64'(Done), 64'(0));
        chk("after_run_cnt_hold", 64'(Cycle_Cnt), 64'(5));
        launch(0, 1'b1);
        Abort = 1'b1;
        wait_done(5, p, b);
        Abort = 1'b0;
        chk("len0_pab_cycles", 64'(p), 64'(0));
        @(negedge Clk);
        launch(5, 1'b1);
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        Start = 1'b1;
        Run_Len = 9;
        @(negedge Clk);
        Start = 1'b0;
        wait_done(20, p, b);
        seen = 0;
        repeat (3) begin
            @(negedge Clk);
            seen += int'(Busy);
        end
        chk("start_in_run_ignored", 64'(seen), 64'(0));
        launch(10, 1'b0);
        @(negedge Clk);
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        chk("abort_pre_cnt", 64'(Cycle_Cnt), 64'(3));
        chk("abort_pre_pab", 64'(dut.pe_array_busy), 64'(1));
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        chk("abort_busy", 64'(Busy), 64'(0));
        chk("abort_pab", 64'(dut.pe_array_busy), 64'(0));
        chk("abort_cnt", 64'(Cycle_Cnt), 64'(3));
        seen = 0;
        repeat (12) begin
            @(negedge Clk);
            seen += int'(Done);
        end
        chk("abort_no_done", 64'(seen), 64'(0));
        launch(4, 1'b0);
        @(negedge Clk);
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        chk("abort_last_busy", 64'(Busy), 64'(0));
        chk("abort_last_cnt", 64'(Cycle_Cnt), 64'(3));
        seen = 0;
        repeat (6) begin
            @(negedge Clk);
            seen += int'(Done);
        end
        chk("abort_last_no_done", 64'(seen), 64'(0));
        launch('1, 1'b1);
        wait_done(70000, p, b);
        chk("max_run_pab_cycles", 64'(p), 64'(65535));
        @(negedge Clk);
        launch(100, 1'b0);
        @(negedge Clk);
        Start = 1'b0;
        repeat (39) @(negedge Clk);
        chk("pre_reset_pab", 64'(dut.pe_array_busy), 64'(1));
        #2 Resetn = 1'b0;
        #1;
        chk("rst_busy", 64'(Busy), 64'(0));
        chk("rst_done", 64'(Done), 64'(0));
        chk("rst_cnt", 64'(Cycle_Cnt), 64'(0));
        chk("rst_pab", 64'(dut.pe_array_busy), 64'(0));
        @(negedge Clk);
        Resetn = 1'b1;
        @(negedge Clk);
        launch(3, 1'b1);
        wait_done(20, p, b);
        chk("post_reset_pab_cycles", 64'(p), 64'(3));
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
